// File: rtl/cnn_input_loader.sv
// Streams one frame (IMG_SIZE*IMG_SIZE Q8.8 pixels, then a label beat) into a register image and starts the CNN.
// Define CNN_LOADER_SAT_EN to clamp pixels to [0.0, 1.0] before storage.
module cnn_input_loader #(
    parameter int IMG_SIZE = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    input  logic [15:0]                              s_data,
    input  logic                                     s_last,
    output logic [IMG_SIZE-1:0][IMG_SIZE-1:0][15:0]  image,
    output logic [15:0]                              label,
    output logic                                     cnn_start,
    input  logic                                     cnn_done,
    output logic                                     frame_err,
    output logic [15:0]                              frame_cnt
);

    localparam int NPIX = IMG_SIZE * IMG_SIZE;
    localparam int CW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   beat_cnt_reg;
    logic [15:0]     label_reg;
    logic            cnn_start_reg;
    logic            frame_err_reg;
    logic [15:0]     frame_cnt_reg;
    logic [15:0]     image_reg [NPIX];

    logic            accept;
    logic            at_label;
    logic            pix_we;
    logic [15:0]     pix_data;

    function automatic logic [15:0] sat_pixel(input logic [15:0] d);
`ifdef CNN_LOADER_SAT_EN
        if (d[15])
            return 16'h0000;
        else if (d > 16'h0100)
            return 16'h0100;
        else
            return d;
`else
        return d;
`endif
    endfunction

    assign s_ready  = (state_reg == LOAD) || (state_reg == DROP);
    assign accept   = s_valid && s_ready;
    assign at_label = (beat_cnt_reg == CW'(NPIX));
    // A beat carrying s_last before the label position is a framing error, so its data is not stored.
    assign pix_we   = accept && (state_reg == LOAD) && !at_label && !s_last;
    assign pix_data = sat_pixel(s_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= LOAD;
            beat_cnt_reg  <= '0;
            label_reg     <= '0;
            cnn_start_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            cnn_start_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (accept) begin
                        if (at_label) begin
                            beat_cnt_reg <= '0;
                            if (s_last) begin
                                label_reg     <= s_data;
                                cnn_start_reg <= 1'b1;
                                state_reg     <= FIRE;
                            end else begin
                                frame_err_reg <= 1'b1;
                                state_reg     <= DROP;
                            end
                        end else if (s_last) begin
                            frame_err_reg <= 1'b1;
                            beat_cnt_reg  <= '0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    state_reg     <= WAIT;
                end
                WAIT: begin
                    if (cnn_done)
                        state_reg <= LOAD;
                end
                DROP: begin
                    if (accept && s_last)
                        state_reg <= LOAD;
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    // One register per pixel, written only when the beat counter points at it.
    generate
        for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    image_reg[gi] <= '0;
                else if (pix_we && (beat_cnt_reg == CW'(gi)))
                    image_reg[gi] <= pix_data;
            end
            assign image[gi / IMG_SIZE][gi % IMG_SIZE] = image_reg[gi];
        end
    endgenerate

    assign label     = label_reg;
    assign cnn_start = cnn_start_reg;
    assign frame_err = frame_err_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_cnn_input_loader.sv
// Directed bench for cnn_input_loader: clean frames, backpressure, framing errors, clamping and reset.
module tb_cnn_input_loader;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       s_valid;
    logic                       s_ready;
    logic [15:0]                s_data;
    logic                       s_last;
    logic [3:0][3:0][15:0]      image;
    logic [15:0]                label;
    logic                       cnn_start;
    logic                       cnn_done;
    logic                       frame_err;
    logic [15:0]                frame_cnt;

    int total = 0;
    int bad   = 0;
    int err_pulses   = 0;
    int start_pulses = 0;

    cnn_input_loader #(.IMG_SIZE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .image     (image),
        .label     (label),
        .cnn_start (cnn_start),
        .cnn_done  (cnn_done),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_pulses++;
        if (cnn_start) start_pulses++;
    end

    function automatic logic [15:0] exp_pix(input logic [15:0] d);
`ifdef CNN_LOADER_SAT_EN
        if (d[15]) return 16'h0000;
        if (d > 16'h0100) return 16'h0100;
`endif
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Offers one beat and returns 1 time unit after the edge that transferred it.
    task automatic beat(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        $display("beat data=%h last=%0d frame_err=%0d cnn_start=%0d", d, l, frame_err, cnn_start);
    endtask

    task automatic clean_frame1();
        for (int k = 0; k < 16; k++) beat(16'((k + 1) * 16), 1'b0);
        beat(16'h0080, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; cnn_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_label", label, 0);
        check("rst_img00", image[0][0], 0);
        check("rst_start", cnn_start, 0);
        check("rst_err", frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", s_ready, 1);

        // Clean frame
        clean_frame1();
        check("f1_start", cnn_start, 1);
        check("f1_img33", image[3][3], 16'h0100);
        check("f1_img12", image[1][2], 16'h0070);
        check("f1_label", label, 16'h0080);
        step();
        check("f1_start_off", cnn_start, 0);
        check("f1_cnt", frame_cnt, 1);
        check("f1_wait_ready", s_ready, 0);

        // Backpressure while waiting on the CNN
        s_valid = 1'b1; s_data = 16'h1234;
        repeat (3) step();
        check("bp_ready", s_ready, 0);
        check("bp_img00", image[0][0], 16'h0010);
        check("bp_cnt", frame_cnt, 1);
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0; s_valid = 1'b0;
        check("bp_release", s_ready, 1);
        check("bp_img00_after", image[0][0], 16'h0010);

        // Early s_last on beat 5
        for (int k = 0; k < 4; k++) beat(16'(16'h0501 + k), 1'b0);
        beat(16'h0505, 1'b1);
        check("early_err", frame_err, 1);
        check("early_img00", image[0][0], exp_pix(16'h0501));
        check("early_img10", image[1][0], 16'h0050);
        step();
        check("early_err_off", frame_err, 0);
        check("early_starts", start_pulses, 1);
        check("early_cnt", frame_cnt, 1);

        for (int k = 0; k < 16; k++) beat(16'((k + 1) * 8), 1'b0);
        beat(16'hFF80, 1'b1);
        check("f2_start", cnn_start, 1);
        check("f2_img00", image[0][0], 16'h0008);
        check("f2_img21", image[2][1], 16'h0050);
        check("f2_label", label, 16'hFF80);
        step();
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        check("f2_cnt", frame_cnt, 2);

        // Missing s_last: 17 beats, then drop until s_last
        for (int k = 0; k < 17; k++) beat(16'h0AAA, 1'b0);
        check("miss_err", frame_err, 1);
        check("miss_ready", s_ready, 1);
        check("miss_label", label, 16'hFF80);
        beat(16'h0BBB, 1'b0);
        beat(16'h0BBB, 1'b0);
        beat(16'h0BBB, 1'b1);
        check("drop_err_off", frame_err, 0);
        check("drop_start", cnn_start, 0);
        check("drop_img00", image[0][0], exp_pix(16'h0AAA));
        check("drop_img33", image[3][3], exp_pix(16'h0AAA));
        check("drop_cnt", frame_cnt, 2);
        check("drop_err_pulses", err_pulses, 2);

        // Out-of-range pixels and a negative label
        beat(16'hFF00, 1'b0);
        beat(16'h0300, 1'b0);
        for (int k = 2; k < 16; k++) beat(16'h0040, 1'b0);
        beat(16'hFF00, 1'b1);
        check("sat_start", cnn_start, 1);
        check("sat_img00", image[0][0], exp_pix(16'hFF00));
        check("sat_img01", image[0][1], exp_pix(16'h0300));
        check("sat_img33", image[3][3], 16'h0040);
        check("sat_label", label, 16'hFF00);
        step();
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        check("sat_cnt", frame_cnt, 3);

        // Reset after beat 8
        for (int k = 0; k < 8; k++) beat(16'h0020, 1'b0);
        rst = 1'b1;
        #1;
        check("mrst_img00", image[0][0], 0);
        check("mrst_img13", image[1][3], 0);
        check("mrst_label", label, 0);
        check("mrst_cnt", frame_cnt, 0);
        check("mrst_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        clean_frame1();
        check("mrst_start", cnn_start, 1);
        check("mrst_f_img33", image[3][3], 16'h0100);
        check("mrst_f_img10", image[1][0], 16'h0050);
        step();
        check("mrst_f_cnt", frame_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
